// File: rtl/tx_mac_if.sv
// tx_mac_if: AXI-Stream byte channel from the TX FIFO into the transmit MAC.
//
// Signals
//   tdata   payload byte (DATA_WIDTH bits, only 8 is meaningful)
//   tvalid  source holds a valid byte
//   tlast   byte is the final payload byte of the frame
//   trdy    sink accepts the byte this cycle (a beat moves on tvalid & trdy)
//
// Modports
//   master  FIFO side: drives tdata/tvalid/tlast, observes trdy
//   slave   MAC side: observes tdata/tvalid/tlast, drives trdy
interface tx_mac_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  trdy;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  trdy
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output trdy
  );

endinterface

// File: rtl/tx_mac.sv
// tx_mac: Ethernet transmit MAC. Pulls payload bytes from the TX FIFO over
// AXI-Stream and sends preamble, SFD, payload, zero pad up to MIN_FRAME and
// (optionally) the FCS toward the RGMII interface block, then holds an
// inter-frame gap of IFG_SIZE byte times.
//
// Ports
//   clk                MAC clock (125 MHz for gigabit)
//   reset_n            synchronous active-low reset
//   s_tx_axis          tx_mac_if.slave: tdata/tvalid/tlast in, trdy out
//   rgmii_mac_tx_data  byte toward the RGMII block
//   rgmii_mac_tx_en    frame in progress
//   rgmii_mac_tx_er    underrun marker, high for exactly one byte
//   mii_select         1 = 10/100 MII (each byte held 2 clk), 0 = gigabit
//
// Configuration macro
//   TX_MAC_FCS_EN  when defined, the CRC-32 generator is built and four FCS
//                  bytes follow the payload/pad. When undefined the frame ends
//                  after payload/pad and goes straight into the gap.
//
// Parameters
//   DATA_WIDTH  byte width of both data paths, only 8 is supported
//   IFG_SIZE    gap length in byte times after the last frame byte
//   MIN_FRAME   minimum bytes ahead of the FCS, short payloads are zero padded
module tx_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int IFG_SIZE   = 12,
  parameter int MIN_FRAME  = 60
) (
  input  logic                  clk,
  input  logic                  reset_n,
  tx_mac_if.slave               s_tx_axis,
  output logic [DATA_WIDTH-1:0] rgmii_mac_tx_data,
  output logic                  rgmii_mac_tx_en,
  output logic                  rgmii_mac_tx_er,
  input  logic                  mii_select
);

  // The state names the byte that will be loaded into the output registers at
  // the next byte tick, so every output byte leaves a register one clk after
  // the decision that produced it.
  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PAYLOAD,
    PAD,
    FCS,
    DRAIN,
    IFG
  } txState_t;

  localparam logic [10:0] MIN_COUNT     = 11'(MIN_FRAME);
  localparam logic [10:0] COUNT_MAX     = 11'h7FF;
  localparam logic [7:0]  PREAMBLE_LAST = 8'd6;
  localparam logic [7:0]  IFG_LAST      = 8'(IFG_SIZE - 1);

`ifdef TX_MAC_FCS_EN
  localparam txState_t AFTER_DATA = FCS;
`else
  localparam txState_t AFTER_DATA = IFG;
`endif

  txState_t              r_state;
  logic                  r_miiMode;
  logic                  r_toggle;
  logic [7:0]            r_phaseCnt;
  logic [10:0]           r_byteCount;
  logic [DATA_WIDTH-1:0] r_txData;
  logic                  r_txEn;
  logic                  r_txEr;

  logic                  w_tick;
  logic                  w_transfer;
  logic [10:0]           w_countNext;

`ifdef TX_MAC_FCS_EN
  logic [31:0]           r_crc;
  logic [31:0]           w_crcPayload;
  logic [31:0]           w_crcPad;

  // Byte-serial reflected CRC-32 (poly 0xEDB88320), data bits taken LSB first.
  function automatic logic [31:0] crcNext(input logic [31:0] crc,
                                          input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign w_crcPayload = crcNext(r_crc, s_tx_axis.tdata);
  assign w_crcPad     = crcNext(r_crc, 8'h00);
`endif

  // IDLE always ticks so a waiting frame starts on the very next clk; outside
  // IDLE the MII mode ticks only on the second clk of each byte.
  assign w_tick = (r_state == IDLE) || !r_miiMode || r_toggle;

  // Ready comes from registered state and the tick only, never from tvalid.
  assign s_tx_axis.trdy = w_tick && ((r_state == PAYLOAD) || (r_state == DRAIN));
  assign w_transfer     = s_tx_axis.tvalid && s_tx_axis.trdy;

  // Frame length counter saturates rather than wrapping on jumbo frames.
  assign w_countNext = (r_byteCount == COUNT_MAX) ? r_byteCount
                                                  : r_byteCount + 11'd1;

  assign rgmii_mac_tx_data = r_txData;
  assign rgmii_mac_tx_en   = r_txEn;
  assign rgmii_mac_tx_er   = r_txEr;

  // Transmit FSM with registered outputs. Outputs only change on a byte tick,
  // which is what holds each byte for two clocks in MII mode.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_miiMode   <= 1'b0;
      r_toggle    <= 1'b0;
      r_phaseCnt  <= 8'd0;
      r_byteCount <= 11'd0;
      r_txData    <= '0;
      r_txEn      <= 1'b0;
      r_txEr      <= 1'b0;
`ifdef TX_MAC_FCS_EN
      r_crc       <= 32'hFFFFFFFF;
`endif
    end else begin
      r_toggle <= (r_state == IDLE) ? 1'b0 : !r_toggle;

      if (w_tick) begin
        case (r_state)
          IDLE: begin
            r_txData <= '0;
            r_txEn   <= 1'b0;
            r_txEr   <= 1'b0;
            if (s_tx_axis.tvalid) begin
              // The first preamble byte is loaded here, so the PREAMBLE
              // state only has the remaining six to send.
              r_state     <= PREAMBLE;
              r_miiMode   <= mii_select;
              r_txData    <= 8'h55;
              r_txEn      <= 1'b1;
              r_phaseCnt  <= 8'd1;
              r_byteCount <= 11'd0;
`ifdef TX_MAC_FCS_EN
              r_crc       <= 32'hFFFFFFFF;
`endif
            end
          end

          PREAMBLE: begin
            r_txData <= 8'h55;
            r_txEn   <= 1'b1;
            if (r_phaseCnt == PREAMBLE_LAST) begin
              r_state <= SFD;
            end else begin
              r_phaseCnt <= r_phaseCnt + 8'd1;
            end
          end

          SFD: begin
            r_txData <= 8'hD5;
            r_txEn   <= 1'b1;
            r_state  <= PAYLOAD;
          end

          PAYLOAD: begin
            r_txEn <= 1'b1;
            if (w_transfer) begin
              r_txData    <= s_tx_axis.tdata;
              r_byteCount <= w_countNext;
`ifdef TX_MAC_FCS_EN
              r_crc       <= w_crcPayload;
`endif
              if (s_tx_axis.tlast) begin
                r_phaseCnt <= 8'd0;
                r_state    <= (w_countNext < MIN_COUNT) ? PAD : AFTER_DATA;
              end
            end else begin
              // FIFO ran dry mid-frame: flag one errored byte, then throw
              // away the rest of the frame.
              r_txData <= '0;
              r_txEr   <= 1'b1;
              r_state  <= DRAIN;
            end
          end

          PAD: begin
            r_txData    <= '0;
            r_txEn      <= 1'b1;
            r_byteCount <= w_countNext;
`ifdef TX_MAC_FCS_EN
            r_crc       <= w_crcPad;
`endif
            if (w_countNext >= MIN_COUNT) begin
              r_phaseCnt <= 8'd0;
              r_state    <= AFTER_DATA;
            end
          end

`ifdef TX_MAC_FCS_EN
          FCS: begin
            // Inverted CRC, least significant byte on the wire first.
            r_txData <= ~r_crc[{r_phaseCnt[1:0], 3'b000} +: 8];
            r_txEn   <= 1'b1;
            if (r_phaseCnt == 8'd3) begin
              r_phaseCnt <= 8'd0;
              r_state    <= IFG;
            end else begin
              r_phaseCnt <= r_phaseCnt + 8'd1;
            end
          end
`endif

          DRAIN: begin
            r_txData <= '0;
            r_txEn   <= 1'b0;
            r_txEr   <= 1'b0;
            if (w_transfer && s_tx_axis.tlast) begin
              r_phaseCnt <= 8'd0;
              r_state    <= IFG;
            end
          end

          IFG: begin
            r_txData <= '0;
            r_txEn   <= 1'b0;
            r_txEr   <= 1'b0;
            if (r_phaseCnt == IFG_LAST) begin
              r_phaseCnt <= 8'd0;
              r_state    <= IDLE;
            end else begin
              r_phaseCnt <= r_phaseCnt + 8'd1;
            end
          end

          default: begin
            r_txData <= '0;
            r_txEn   <= 1'b0;
            r_txEr   <= 1'b0;
            r_state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_mac.sv
// tb_tx_mac: scoreboard bench for tx_mac. Every frame handed to the MAC
// pushes its expected wire bytes (preamble, SFD, payload, pad, FCS when
// TX_MAC_FCS_EN is defined, or the underrun byte) into a queue; a monitor
// pops and compares one entry per clk while tx_en is high and records the
// lengths of tx_en high and low runs for frame-length and gap checks.
module tb_tx_mac;

  localparam int MIN_FRAME = 60;
  localparam int IFG_SIZE  = 12;
`ifdef TX_MAC_FCS_EN
  localparam int FCS_BYTES = 4;
`else
  localparam int FCS_BYTES = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       er;
    logic       checkData;
  } expByte_t;

  logic       clk;
  logic       reset_n;
  logic       miiSelect;
  logic [7:0] txData;
  logic       txEn;
  logic       txEr;

  tx_mac_if #(.DATA_WIDTH(8)) axis ();

  tx_mac #(
    .DATA_WIDTH(8),
    .IFG_SIZE  (IFG_SIZE),
    .MIN_FRAME (MIN_FRAME)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .s_tx_axis        (axis),
    .rgmii_mac_tx_data(txData),
    .rgmii_mac_tx_en  (txEn),
    .rgmii_mac_tx_er  (txEr),
    .mii_select       (miiSelect)
  );

  expByte_t   expQ[$];
  int         runQ[$];
  int         gapQ[$];
  logic [7:0] frameBytes[$];

  int totalChecks = 0;
  int badChecks   = 0;
  bit suspend;
  bit gapTrdyCheck;
  int trdyCount;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

`ifdef TX_MAC_FCS_EN
  // Bit-at-a-time reference CRC-32 (reflected, LSB first).
  function automatic logic [31:0] crcModel(input logic [31:0] crc,
                                           input logic [7:0]  b);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int k = 0; k < 8; k++) begin
      fb = c[0] ^ b[k];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction
`endif

  function automatic int enLen(input int len, input bit mii);
    int body;
    body = (len < MIN_FRAME) ? MIN_FRAME : len;
    return (8 + body + FCS_BYTES) * (mii ? 2 : 1);
  endfunction

  function automatic int runAt(input int idx);
    return (runQ.size() > idx) ? runQ[idx] : -1;
  endfunction

  function automatic int gapAt(input int idx);
    return (gapQ.size() > idx) ? gapQ[idx] : -1;
  endfunction

  // MII holds every byte for two clocks, so the entry is expected twice.
  task automatic pushByte(input logic [7:0] d, input logic er, input logic chk);
    expByte_t e;
    e.data      = d;
    e.er        = er;
    e.checkData = chk;
    expQ.push_back(e);
    if (miiSelect) expQ.push_back(e);
  endtask

  task automatic buildExpected(input int len, input int underrunAt);
    int         total;
    logic [7:0] b;
`ifdef TX_MAC_FCS_EN
    logic [31:0] crc;
    crc = 32'hFFFFFFFF;
`endif
    for (int k = 0; k < 7; k++) pushByte(8'h55, 1'b0, 1'b1);
    pushByte(8'hD5, 1'b0, 1'b1);
    total = (len < MIN_FRAME) ? MIN_FRAME : len;
    for (int k = 0; k < total; k++) begin
      if (underrunAt >= 0 && k == underrunAt) begin
        pushByte(8'h00, 1'b1, 1'b0);
        return;
      end
      b = (k < len) ? frameBytes[k] : 8'h00;
      pushByte(b, 1'b0, 1'b1);
`ifdef TX_MAC_FCS_EN
      crc = crcModel(crc, b);
`endif
    end
`ifdef TX_MAC_FCS_EN
    crc = ~crc;
    for (int k = 0; k < 4; k++) pushByte(crc[8*k +: 8], 1'b0, 1'b1);
`endif
  endtask

  // Drives frameBytes on negedges; a beat moves when trdy is seen high.
  // underrunAt >= 0 withholds tvalid for 3 clocks once that many bytes moved;
  // stopAt >= 0 stops driving after that many bytes (used for reset abort).
  task automatic applyStimulus(input int len, input int underrunAt,
                               input int stopAt);
    int i        = 0;
    int dropLeft = 3;
    int guard    = 0;
    int limit;
    limit = (stopAt >= 0) ? stopAt : len;
    buildExpected(len, underrunAt);
    while (i < limit && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (underrunAt >= 0 && i == underrunAt && dropLeft > 0) begin
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        dropLeft--;
      end else begin
        axis.tvalid = 1'b1;
        axis.tdata  = frameBytes[i];
        axis.tlast  = (i == len - 1);
        if (axis.trdy) i++;
      end
    end
    checkOutput("bytesAccepted", i, limit);
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    @(negedge clk);
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    while ((expQ.size() != 0 || txEn) && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    repeat (40) @(negedge clk);
    checkOutput("frameComplete", expQ.size(), 0);
  endtask

  task automatic clearStats();
    runQ.delete();
    gapQ.delete();
    trdyCount = 0;
  endtask

  task automatic fillCount(input int len);
    frameBytes.delete();
    for (int k = 0; k < len; k++) frameBytes.push_back(8'(k));
  endtask

  task automatic fillText();
    frameBytes.delete();
    for (int k = 0; k < 9; k++) frameBytes.push_back(8'h31 + 8'(k));
  endtask

  task automatic fillRandom(input int len);
    frameBytes.delete();
    for (int k = 0; k < len; k++) frameBytes.push_back(8'($urandom_range(0, 255)));
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    expByte_t e;
    bit prevEn   = 1'b0;
    bit prevTrdy = 1'b0;
    int enRun    = 0;
    int lowRun   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (suspend) begin
        prevEn   = 1'b0;
        prevTrdy = 1'b0;
        enRun    = 0;
        lowRun   = 0;
      end else begin
        if (txEn && !prevEn) begin
          gapQ.push_back(lowRun);
          lowRun = 0;
        end
        if (!txEn && prevEn) begin
          runQ.push_back(enRun);
          enRun = 0;
        end
        if (txEn) begin
          enRun++;
          if (expQ.size() == 0) begin
            checkOutput("spuriousTxEn", txEn, 1'b0);
          end else begin
            e = expQ.pop_front();
            if (e.checkData) checkOutput("txData", txData, e.data);
            checkOutput("txEr", txEr, e.er);
          end
        end else begin
          lowRun++;
          checkOutput("txErIdle", txEr, 1'b0);
          if (gapTrdyCheck) checkOutput("trdyInGap", axis.trdy, 1'b0);
        end
        if (miiSelect && axis.trdy) checkOutput("miiTrdySpacing", prevTrdy, 1'b0);
        if (axis.trdy) trdyCount++;
        prevEn   = txEn;
        prevTrdy = axis.trdy;
      end
    end
  end

  initial begin : watchdog
    #500000;
    badChecks++;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  initial begin : main
    reset_n      = 1'b0;
    miiSelect    = 1'b0;
    suspend      = 1'b1;
    gapTrdyCheck = 1'b0;
    trdyCount    = 0;
    axis.tdata   = 8'h00;
    axis.tvalid  = 1'b0;
    axis.tlast   = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    checkOutput("rstTxEn", txEn, 1'b0);
    checkOutput("rstTxEr", txEr, 1'b0);
    checkOutput("rstTxData", txData, 8'h00);
    checkOutput("rstTrdy", axis.trdy, 1'b0);
    reset_n = 1'b1;
    suspend = 1'b0;
    repeat (3) @(negedge clk);

    // 60-byte counting frame followed directly by the short "123456789" frame
    $display("[TB] 60-byte frame then 9-byte padded frame, back to back");
    clearStats();
    fillCount(60);
    applyStimulus(60, -1, -1);
    fillText();
    applyStimulus(9, -1, -1);
    waitIdle(600);
    checkOutput("runLen60", runAt(0), enLen(60, 1'b0));
    checkOutput("runLen9", runAt(1), enLen(9, 1'b0));
    checkOutput("gapAfter60", gapAt(1), IFG_SIZE);

    // Two 64-byte frames with the FIFO always valid
    $display("[TB] two 64-byte frames, FIFO always valid");
    clearStats();
    gapTrdyCheck = 1'b1;
    fillRandom(64);
    applyStimulus(64, -1, -1);
    fillRandom(64);
    applyStimulus(64, -1, -1);
    waitIdle(600);
    gapTrdyCheck = 1'b0;
    checkOutput("runLen64a", runAt(0), enLen(64, 1'b0));
    checkOutput("runLen64b", runAt(1), enLen(64, 1'b0));
    checkOutput("gap64", gapAt(1), IFG_SIZE);

    // Underrun after 20 payload bytes, then a clean frame
    $display("[TB] underrun after payload byte 20");
    clearStats();
    fillRandom(60);
    applyStimulus(60, 20, -1);
    fillRandom(60);
    applyStimulus(60, -1, -1);
    waitIdle(600);
    checkOutput("runLenUnderrun", runAt(0), 8 + 20 + 1);
    checkOutput("runLenAfterUnderrun", runAt(1), enLen(60, 1'b0));

    // MII mode: every byte held two clocks
    $display("[TB] 60-byte frame in MII mode");
    miiSelect = 1'b1;
    clearStats();
    fillCount(60);
    applyStimulus(60, -1, -1);
    waitIdle(800);
    checkOutput("runLenMii", runAt(0), enLen(60, 1'b1));
    checkOutput("trdyPulsesMii", trdyCount, 60);
    miiSelect = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of the payload
    $display("[TB] reset at payload byte 30");
    fillRandom(60);
    applyStimulus(60, -1, 30);
    @(negedge clk);
    reset_n     = 1'b0;
    suspend     = 1'b1;
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkOutput("abortTxEn", txEn, 1'b0);
    checkOutput("abortTxEr", txEr, 1'b0);
    checkOutput("abortTrdy", axis.trdy, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    suspend = 1'b0;
    clearStats();
    fillRandom(60);
    applyStimulus(60, -1, -1);
    waitIdle(600);
    checkOutput("runLenAfterReset", runAt(0), enLen(60, 1'b0));

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
